// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the branch resolve queue.
//   BRQ_DEPTH   : default number of in-flight branch entries (power of two, >= 2)
//   BRQ_PC_INCR : default sequential PC increment
//   entry_t     : one in-flight branch {pc, pred_valid, pred_addr}
//   brq_cnt_w   : occupancy counter width for a given depth (must reach DEPTH)
package branch_resolve_queue_pkg;

  localparam int BRQ_DEPTH   = 4;
  localparam int BRQ_PC_INCR = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_valid;
    logic [31:0] pred_addr;
  } entry_t;

  function automatic int brq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/branch_entry_fifo.sv
// Entry storage for the branch resolve queue: circular buffer with head/tail
// pointers and an occupancy count. Push/pop qualification is done by the
// caller; flush empties the queue and dominates push/pop on the same edge.
// Storage contents are not reset, validity comes only from the count.
// Ports:
//   CLK, RESET : clock, asynchronous active-high reset
//   i_push     : write i_wdata at tail
//   i_pop      : retire head entry
//   i_flush    : discard all entries (count, head, tail -> 0)
//   i_wdata    : entry to push
//   o_head     : oldest entry (meaningful only when o_count != 0)
//   o_count    : number of valid entries
module branch_entry_fifo
  import branch_resolve_queue_pkg::*;
#(
  parameter  int DEPTH = BRQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = brq_cnt_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  entry_t           i_wdata,
  output entry_t           o_head,
  output logic [CNT_W-1:0] o_count
);

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (i_push && !i_flush) r_mem[r_tail] <= i_wdata;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: holds fetched branches with their BTB prediction in
// program order, compares each against the actual outcome when execute
// resolves the oldest one, and produces a BTB update pulse and a fetch
// redirect pulse one cycle after the resolve.
// Ports:
//   CLK, RESET                  : clock, asynchronous active-high reset
//   Alloc_*_IN                  : new branch from fetch {pc, pred valid, pred addr}
//   Resolve_*_IN                : resolution of the oldest branch {valid, taken, target}
//   Full_OUT/Empty_OUT/Count_OUT: occupancy, combinational from registered count
//   Resolution_OUT, Branch_addr_OUT, Branch_resolved_addr_OUT : BTB write pulse
//   Mispredict_OUT, Redirect_addr_OUT                         : fetch redirect pulse
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter  int DEPTH   = BRQ_DEPTH,
  parameter  int PC_INCR = BRQ_PC_INCR,
  localparam int CNT_W   = brq_cnt_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Alloc_Valid_IN,
  input  logic [31:0]      Alloc_PC_IN,
  input  logic             Alloc_Pred_Valid_IN,
  input  logic [31:0]      Alloc_Pred_Addr_IN,
  input  logic             Resolve_Valid_IN,
  input  logic             Resolve_Taken_IN,
  input  logic [31:0]      Resolve_Target_IN,
  output logic             Full_OUT,
  output logic             Empty_OUT,
  output logic [CNT_W-1:0] Count_OUT,
  output logic             Resolution_OUT,
  output logic [31:0]      Branch_addr_OUT,
  output logic [31:0]      Branch_resolved_addr_OUT,
  output logic             Mispredict_OUT,
  output logic [31:0]      Redirect_addr_OUT
);

  entry_t           w_head;
  entry_t           w_wdata;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic [31:0]      w_seq_next;
  logic [31:0]      w_actual_next;
  logic [31:0]      w_pred_next;
  logic             w_pop;
  logic             w_push;
  logic             w_mispredict;
  logic             w_btb_update;

  logic             r_mispredict;
  logic [31:0]      r_redirect_addr;
  logic             r_resolution;
  logic [31:0]      r_branch_addr;
  logic [31:0]      r_resolved_addr;

  assign w_full  = (w_count == CNT_W'(DEPTH));
  assign w_empty = (w_count == '0);

  assign w_seq_next    = w_head.pc + 32'(PC_INCR);
  assign w_actual_next = Resolve_Taken_IN  ? Resolve_Target_IN : w_seq_next;
  assign w_pred_next   = w_head.pred_valid ? w_head.pred_addr  : w_seq_next;

  assign w_pop        = Resolve_Valid_IN && !w_empty;
  assign w_mispredict = w_pop && (w_actual_next != w_pred_next);

  // BTB only learns taken branches with a real target it does not already hold;
  // zero is the BTB's "no entry" marker and can never be written.
  assign w_btb_update = w_pop && Resolve_Taken_IN && (Resolve_Target_IN != '0) &&
                        (!w_head.pred_valid || (w_head.pred_addr != Resolve_Target_IN));

  // A full queue drops the alloc even if a pop frees a slot this cycle;
  // a mispredict flushes everything, including the branch being fetched now.
  assign w_push = Alloc_Valid_IN && !w_full && !w_mispredict;

  assign w_wdata.pc         = Alloc_PC_IN;
  assign w_wdata.pred_valid = Alloc_Pred_Valid_IN;
  assign w_wdata.pred_addr  = Alloc_Pred_Addr_IN;

  branch_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_mispredict),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_mispredict    <= 1'b0;
      r_redirect_addr <= '0;
      r_resolution    <= 1'b0;
      r_branch_addr   <= '0;
      r_resolved_addr <= '0;
    end else begin
      r_mispredict    <= w_mispredict;
      r_redirect_addr <= w_mispredict ? w_actual_next : '0;
      r_resolution    <= w_btb_update;
      r_branch_addr   <= w_btb_update ? w_head.pc : '0;
      r_resolved_addr <= w_btb_update ? Resolve_Target_IN : '0;
    end
  end

  assign Full_OUT                 = w_full;
  assign Empty_OUT                = w_empty;
  assign Count_OUT                = w_count;
  assign Mispredict_OUT           = r_mispredict;
  assign Redirect_addr_OUT        = r_redirect_addr;
  assign Resolution_OUT           = r_resolution;
  assign Branch_addr_OUT          = r_branch_addr;
  assign Branch_resolved_addr_OUT = r_resolved_addr;

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 Parameter DEPTH, default 4, in-flight branch entries; power of two, minimum 2.
REQ-002 Parameter PC_INCR, default 4, sequential PC increment.
REQ-003 The clock port SHALL be CLK, input, 1 bit; one clock only, all state on posedge CLK.
REQ-004 The reset port SHALL be RESET, input, 1 bit; asynchronous, active-high.
REQ-005 Alloc_Valid_IN, input, 1: fetch issues a branch this cycle.
REQ-006 Alloc_PC_IN, input, 32: PC of the issued branch.
REQ-007 Alloc_Pred_Valid_IN, input, 1: BTB Valid_OUT captured at fetch.
REQ-008 Alloc_Pred_Addr_IN, input, 32: BTB Addr_OUT captured at fetch.
REQ-009 Resolve_Valid_IN, input, 1: execute resolves the oldest in-flight branch.
REQ-010 Resolve_Taken_IN, input, 1: actual direction.
REQ-011 Resolve_Target_IN, input, 32: actual taken target.
REQ-012 Full_OUT, output, 1; Empty_OUT, output, 1; Count_OUT, output, log2(DEPTH)+1: occupancy.
REQ-013 Resolution_OUT, output, 1; Branch_addr_OUT, output, 32; Branch_resolved_addr_OUT, output, 32: BTB update port.
REQ-014 Mispredict_OUT, output, 1; Redirect_addr_OUT, output, 32: fetch redirect.

Function
REQ-015 Queue SHALL be in-order FIFO of entries {pc, pred_valid, pred_addr}; head = oldest.
REQ-016 Push when Alloc_Valid_IN=1 and Full_OUT=0; alloc while Full_OUT=1 SHALL be dropped, no state change, even if a pop occurs the same cycle.
REQ-017 Full_OUT/Empty_OUT/Count_OUT SHALL be combinational from registered count (Full = count==DEPTH, Empty = count==0).
REQ-018 Resolve_Valid_IN while Empty_OUT=1 SHALL be ignored; no output pulses.
REQ-019 Valid resolve SHALL pop head; actual_next = Taken ? Resolve_Target_IN : head.pc+PC_INCR; pred_next = pred_valid ? pred_addr : head.pc+PC_INCR; 32-bit add, wraps mod 2^32.
REQ-020 Mispredict_OUT SHALL pulse one cycle, registered, the cycle after resolve when actual_next != pred_next; Redirect_addr_OUT = actual_next that cycle, else 0.
REQ-021 Resolution_OUT SHALL pulse one cycle, registered, when Taken=1, Resolve_Target_IN != 0, and (pred_valid=0 or pred_addr != Resolve_Target_IN); Branch_addr_OUT = head.pc, Branch_resolved_addr_OUT = Resolve_Target_IN; both 0 when no pulse.
REQ-022 Not-taken resolves SHALL never assert Resolution_OUT (BTB has no invalidate); target 0 SHALL never be written (0 means no entry).
REQ-023 On mispredict the whole queue SHALL be flushed the same edge as the pop (count=0, head=tail=0); a same-cycle alloc SHALL be dropped.
REQ-024 Simultaneous push and non-mispredicting pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-025 Latency: resolve in cycle N -> outputs valid cycle N+1 only.

Reset
REQ-026 RESET=1 SHALL immediately clear head, tail, count, all pulse and address outputs to 0; Empty_OUT=1, Full_OUT=0.
REQ-027 Reset mid-operation SHALL discard all entries; no Resolution_OUT or Mispredict_OUT pulse emitted for them.
REQ-028 Entry storage contents need no reset; validity derives solely from count.

Structure
REQ-029 Shared package SHALL hold DEPTH, PC_INCR, entry record layout, and count width.
REQ-030 Entry storage with read/write pointers SHALL be a sub-module branch_entry_fifo; compare/update logic in top.

Verification
REQ-031 Alloc PC=0x100 pred invalid; resolve taken target 0x200 -> next cycle Resolution_OUT=1, Branch_addr_OUT=0x100, resolved=0x200, Mispredict_OUT=1, Redirect=0x200.
REQ-032 Alloc PC=0x100 pred 0x200; resolve taken 0x200 -> no pulses, Count_OUT 1->0.
REQ-033 Alloc 4 branches (0x10,0x20,0x30,0x40), 5th alloc 0x50 -> Full_OUT=1, 0x50 dropped; four correct resolves drain 0x10..0x40 in order.
REQ-034 Three entries, head pred 0x300 resolves not-taken at PC 0x100 -> Mispredict_OUT=1, Redirect=0x104, Resolution_OUT=0, Count_OUT=0, same-cycle alloc dropped.
REQ-035 Resolve taken target 0 with pred invalid -> Mispredict_OUT=1, Redirect=0, Resolution_OUT=0.
REQ-036 Two entries, assert RESET between edges -> outputs 0, Empty_OUT=1 immediately; later resolve ignored.
